status_tx_blk: RTL and testbench
================================

# status_tx_blk

Serial status reporter for the segway: the transmit side of the phone link whose receive side carries the power-up/shut-down commands. It watches the power state, rider presence and battery-low flag. On any change, or on an explicit request, it sends a fixed 3-byte status packet to the phone over an 8N1 UART line. The block contains its own baud generator and shift register and sits beside the authentication receiver at the top level.

## Interface
- BAUD_DIV, default 2604: clk cycles per UART bit (50 MHz / 19200); legal range 2..65535.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pwr_up  in  1  current power state from the authentication logic; synchronous to clk.
- rider_off  in  1  rider-absent flag; synchronous to clk.
- batt_low  in  1  battery-low flag; synchronous to clk.
- snd  in  1  single-cycle request to send a packet even without a change.
- TX  out  1  UART serial output, idle high.
- busy  out  1  high while a packet is on the line.
- pkt_done  out  1  single-cycle pulse when the last stop bit of a packet completes.

## Operation
- Status vector: stat = {batt_low, rider_off, pwr_up}.
- prev_stat register:
  - Reset value 3'b000.
  - Updated with stat every clock.
- pending flag:
  - Set on any edge where stat != prev_stat or snd=1.
  - Cleared on the edge where the packet FSM leaves IDLE, unless a new set condition occurs on that same edge; set wins.
- Packet format, three bytes, in this order:
  - HDR = 8'hA5.
  - STS = {5'b00000, snapshot}.
  - CHK = 8'hA5 ^ STS.
- Snapshot:
  - stat is captured on the edge leaving IDLE.
  - It is held constant for the whole packet.
- Packet FSM states:
  - IDLE: TX=1, busy=0. If pending, go to HDR: load the byte shifter with 8'hA5, capture the snapshot, drive the start bit.
  - HDR: after the HDR stop bit, go to STS with no idle gap; the STS start bit follows the stop bit directly.
  - STS: after its stop bit, go to CHK.
  - CHK: after its stop bit, go to IDLE and pulse pkt_done.
- Byte framing:
  - Each byte is sent as start bit (0), data bits 0..7 LSB first, stop bit (1).
  - Each bit is held for exactly BAUD_DIV clocks.
  - The baud counter is 16 bits wide and resets to 0 at every bit boundary.
  - The bit counter counts 0..9 per byte.
- Back-to-back packets:
  - If pending is set while a packet is in flight (input change or snd), a second packet starts after exactly one IDLE cycle (TX=1).
  - The second packet carries the stat value sampled at its own start.
  - Multiple changes during one packet produce only one follow-up packet.
- Reset behaviour:
  - Reset asserted mid-packet forces TX=1, busy=0, pkt_done=0, pending=0 and prev_stat=000 immediately.
  - The partial packet is abandoned and never resent.
  - After reset release, a packet is sent only if stat != 000 or snd is asserted.

## Timing
- Reset values: TX=1, busy=0, pkt_done=0, FSM=IDLE, baud counter=0, bit counter=0.
- Latency for an input change:
  - The change is first seen at edge k, which sets pending.
  - TX falls (start bit) and busy rises at edge k+1.
- Latency for snd: snd high before edge k gives TX low from edge k+1.
- Byte duration is 10*BAUD_DIV clocks. Packet duration is 30*BAUD_DIV clocks from the TX falling edge to the pkt_done pulse.
- pkt_done and busy relationship:
  - pkt_done is high for the one clock at which the FSM re-enters IDLE.
  - busy falls on the same edge as pkt_done rises.
- snd during busy is recorded in pending, not dropped.
- snd on the same edge as an input change produces one packet, not two.

## Test plan
- Reset check, BAUD_DIV=8: hold inputs at 0 with no snd for 1000 clocks -> TX stays 1, busy=0, pkt_done never pulses.
- Basic packet, BAUD_DIV=8: pwr_up 0->1 -> after 1 clock, bytes A5, 01, A4 are decoded by the bench UART model; each bit is 8 clocks; pkt_done pulses 240 clocks after TX falls.
- Multi-bit status: rider_off=1 and pwr_up=1 set together -> bytes A5, 03, A6. Then batt_low rises -> A5, 07, A2.
- Mid-packet change: during the STS byte of a pwr_up=1 packet, rider_off goes 0->1->0->1 -> the first packet is unchanged (A5, 01, A4); then after a 1-clock idle gap exactly one packet A5, 03, A6 is sent.
- snd handling: snd pulse with status 001 while idle -> packet A5, 01, A4. snd coincident with an input change -> one packet only.
- Reset mid-packet: assert rst_n=0 during the HDR data bits -> TX=1 and busy=0 in the same cycle. After release with stat=001 -> a fresh full packet A5, 01, A4.

Source files
------------

// File: rtl/status_tx_blk.sv
// Serial status reporter: sends a 3-byte {A5, status, checksum} packet over 8N1 UART
// whenever {batt_low, rider_off, pwr_up} changes or a send is requested.
module status_tx_blk #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwr_up,
  input  logic rider_off,
  input  logic batt_low,
  input  logic snd,
  output logic TX,
  output logic busy,
  output logic pkt_done
);

  localparam logic [15:0] BaudMax = 16'(BAUD_DIV - 1);
  localparam logic [7:0]  HdrByte = 8'hA5;

  typedef enum logic [1:0] {StIdle, StHdr, StSts, StChk} state_e;

  state_e      state_q;
  logic [2:0]  stat;
  logic [2:0]  prev_stat_q;
  logic [2:0]  snap_q;
  logic        pending_q;
  logic [15:0] baud_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  sts_byte;
  logic [7:0]  chk_byte;
  logic        set_pend;
  logic        start_pkt;
  logic        bit_end;

  assign stat      = {batt_low, rider_off, pwr_up};
  assign set_pend  = (stat != prev_stat_q) | snd;
  assign start_pkt = (state_q == StIdle) & pending_q;
  assign sts_byte  = {5'b00000, snap_q};
  assign chk_byte  = HdrByte ^ sts_byte;
  assign bit_end   = (baud_cnt_q == BaudMax);

  // A new request on the same edge the FSM leaves IDLE must survive the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_stat_q <= 3'b000;
      pending_q   <= 1'b0;
    end else begin
      prev_stat_q <= stat;
      if (set_pend) begin
        pending_q <= 1'b1;
      end else if (start_pkt) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      TX         <= 1'b1;
      busy       <= 1'b0;
      pkt_done   <= 1'b0;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      snap_q     <= 3'b000;
    end else begin
      pkt_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pending_q) begin
            state_q    <= StHdr;
            shift_q    <= HdrByte;
            snap_q     <= stat;
            TX         <= 1'b0;
            busy       <= 1'b1;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 4'd0;
          end
        end
        default: begin
          if (!bit_end) begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end else begin
            baud_cnt_q <= 16'd0;
            if (bit_cnt_q == 4'd9) begin
              // Stop bit done: next byte's start bit follows with no gap.
              bit_cnt_q <= 4'd0;
              unique case (state_q)
                StHdr: begin
                  state_q <= StSts;
                  shift_q <= sts_byte;
                  TX      <= 1'b0;
                end
                StSts: begin
                  state_q <= StChk;
                  shift_q <= chk_byte;
                  TX      <= 1'b0;
                end
                default: begin
                  state_q  <= StIdle;
                  TX       <= 1'b1;
                  busy     <= 1'b0;
                  pkt_done <= 1'b1;
                end
              endcase
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd8) begin
                TX <= 1'b1;
              end else begin
                TX      <= shift_q[0];
                shift_q <= {1'b0, shift_q[7:1]};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_tx_blk.sv
// Bench for status_tx_blk: UART monitor decodes TX and checks bytes against a scoreboard queue.
module tb_status_tx_blk;

  localparam int unsigned BAUD_DIV = 8;
  localparam int unsigned PKT_LEN  = 30 * BAUD_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwr_up = 1'b0;
  logic rider_off = 1'b0;
  logic batt_low = 1'b0;
  logic snd = 1'b0;
  logic TX;
  logic busy;
  logic pkt_done;

  int checks = 0;
  int errors = 0;
  int unsigned rst_events = 0;
  int unsigned pkt_cnt = 0;
  logic [7:0] exp_q[$];

  status_tx_blk #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwr_up   (pwr_up),
    .rider_off(rider_off),
    .batt_low (batt_low),
    .snd      (snd),
    .TX       (TX),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;

  always @(negedge rst_n) rst_events++;
  always @(negedge clk) if (pkt_done === 1'b1) pkt_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input logic [7:0] sts);
    exp_q.push_back(8'hA5);
    exp_q.push_back(sts);
    exp_q.push_back(8'hA5 ^ sts);
  endtask

  // Counts clocks from the current cycle until pkt_done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (pkt_done !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // UART monitor: samples mid-bit; bytes cut short by a reset are discarded.
  initial begin : uart_mon
    logic [7:0] rx;
    logic start_b;
    logic stop_b;
    logic [7:0] exp_b;
    int unsigned ev;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        ev = rst_events;
        repeat (BAUD_DIV / 2) @(negedge clk);
        start_b = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD_DIV) @(negedge clk);
          rx[i] = TX;
        end
        repeat (BAUD_DIV) @(negedge clk);
        stop_b = TX;
        if (ev == rst_events) begin
          check("uart_framing", {30'd0, start_b, stop_b}, 32'd1);
          if (exp_q.size() == 0) begin
            check("uart_unexpected_byte", {24'd0, rx}, 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            check("uart_byte", {24'd0, rx}, {24'd0, exp_b});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] stat;
    logic       snd;
    logic [7:0] sts;
  } vec_t;

  initial begin : main
    vec_t vecs[6];
    int n;
    int unsigned base;
    logic bad_tx;
    logic bad_busy;

    vecs[0] = '{stat: 3'b001, snd: 1'b0, sts: 8'h01};
    vecs[1] = '{stat: 3'b011, snd: 1'b0, sts: 8'h03};
    vecs[2] = '{stat: 3'b111, snd: 1'b0, sts: 8'h07};
    vecs[3] = '{stat: 3'b111, snd: 1'b1, sts: 8'h07};
    vecs[4] = '{stat: 3'b110, snd: 1'b1, sts: 8'h06};
    vecs[5] = '{stat: 3'b000, snd: 1'b0, sts: 8'h00};

    // Reset values and quiet line.
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    rst_n = 1'b1;
    bad_tx = 1'b0;
    bad_busy = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (TX !== 1'b1) bad_tx = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check("quiet_tx", {31'd0, bad_tx}, 32'd0);
    check("quiet_busy", {31'd0, bad_busy}, 32'd0);
    check("quiet_pkts", pkt_cnt, 32'd0);

    // Table-driven packets.
    for (int v = 0; v < 6; v++) begin
      base = pkt_cnt;
      @(negedge clk);
      {batt_low, rider_off, pwr_up} = vecs[v].stat;
      snd = vecs[v].snd;
      push_pkt(vecs[v].sts);
      @(posedge clk);
      #1;
      snd = 1'b0;
      check("pend_tx_high", {31'd0, TX}, 32'd1);
      @(posedge clk);
      #1;
      check("start_tx", {31'd0, TX}, 32'd0);
      check("start_busy", {31'd0, busy}, 32'd1);
      wait_done(n);
      check("pkt_len", n, PKT_LEN);
      check("done_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check("done_pulse_width", {31'd0, pkt_done}, 32'd0);
      repeat (30) @(posedge clk);
      #1;
      check("single_pkt", pkt_cnt - base, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Mid-packet changes: packet unchanged, one follow-up after a 1-clock gap.
    base = pkt_cnt;
    @(negedge clk);
    pwr_up = 1'b1;
    push_pkt(8'h01);
    push_pkt(8'h03);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_start_tx", {31'd0, TX}, 32'd0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rider_off = 1'b1;
    repeat (3) @(negedge clk);
    rider_off = 1'b0;
    repeat (3) @(negedge clk);
    rider_off = 1'b1;
    wait_done(n);
    check("gap_tx", {31'd0, TX}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_start_tx", {31'd0, TX}, 32'd0);
    check("b2b_start_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("b2b_pkt_len", n, PKT_LEN);
    repeat (40) @(posedge clk);
    #1;
    check("mid_pkt_count", pkt_cnt - base, 32'd2);

    // Reset during HDR data bits abandons the packet.
    @(negedge clk);
    rider_off = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("abort_start_tx", {31'd0, TX}, 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    base = pkt_cnt;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, TX}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, pkt_done}, 32'd0);
    repeat (100) @(negedge clk);
    exp_q.delete();
    push_pkt(8'h01);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_pend_tx", {31'd0, TX}, 32'd1);
    @(posedge clk);
    #1;
    check("post_rst_start_tx", {31'd0, TX}, 32'd0);
    // snd while busy is remembered and yields one more packet.
    repeat (50) @(posedge clk);
    @(negedge clk);
    snd = 1'b1;
    push_pkt(8'h01);
    @(negedge clk);
    snd = 1'b0;
    wait_done(n);
    check("post_rst_done", {31'd0, pkt_done}, 32'd1);
    @(posedge clk);
    #1;
    check("snd_busy_start_tx", {31'd0, TX}, 32'd0);
    wait_done(n);
    check("snd_busy_pkt_len", n, PKT_LEN);
    repeat (50) @(posedge clk);
    #1;
    check("rst_pkt_count", pkt_cnt - base, 32'd2);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
